// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : dlx_mem_pkg                                            |
// | Description : Shared encodings for the DLX memory-access stage:      |
// |               access-size codes, FSM state type and byte-enable      |
// |               patterns. All vectors are big-endian ([0] = MSB).      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package dlx_mem_pkg;

  // Access size (DSize). Both 2'b10 and 2'b11 select a word access.
  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;

  // Memory-transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Byte enables; element [0] enables byte lane [0:7].
  localparam logic [0:3] BE_BYTE0 = 4'b1000;
  localparam logic [0:3] BE_HALF0 = 4'b1100;
  localparam logic [0:3] BE_HALF1 = 4'b0011;
  localparam logic [0:3] BE_WORD  = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_align                                              |
// | Description : Combinational alignment for the memory stage. Builds   |
// |               lane-replicated store data and byte enables, extracts  |
// |               and sign/zero-extends load data, flags misalignment.   |
// | Ports       : addr_off_i  - byte offset within word (addr[30:31])    |
// |               dsize_i     - access size code                         |
// |               store_val_i - raw store value                          |
// |               load_sign_i - sign-extend loaded byte/half             |
// |               rdata_i     - word returned by data memory             |
// |               wdata_o     - replicated store data                    |
// |               be_o        - byte enables                             |
// |               load_data_o - aligned, extended load value             |
// |               misalign_o  - access not naturally aligned             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_align
  import dlx_mem_pkg::*;
(
  input  logic [0:1]  addr_off_i,
  input  logic [1:0]  dsize_i,
  input  logic [0:31] store_val_i,
  input  logic        load_sign_i,
  input  logic [0:31] rdata_i,
  output logic [0:31] wdata_o,
  output logic [0:3]  be_o,
  output logic [0:31] load_data_o,
  output logic        misalign_o
);

  logic [0:7]  w_byte;
  logic [0:15] w_half;

  always_comb begin
    // Byte lane k occupies rdata[8k:8k+7]; halves sit at [0:15] / [16:31].
    w_byte      = rdata_i[{addr_off_i, 3'b000} +: 8];
    w_half      = addr_off_i[0] ? rdata_i[16:31] : rdata_i[0:15];
    wdata_o     = store_val_i;
    be_o        = BE_WORD;
    load_data_o = rdata_i;
    misalign_o  = 1'b0;
    case (dsize_i)
      DS_BYTE: begin
        wdata_o     = {4{store_val_i[24:31]}};
        be_o        = BE_BYTE0 >> addr_off_i;
        load_data_o = {{24{load_sign_i & w_byte[0]}}, w_byte};
      end
      DS_HALF: begin
        wdata_o     = {2{store_val_i[16:31]}};
        be_o        = addr_off_i[0] ? BE_HALF1 : BE_HALF0;
        load_data_o = {{16{load_sign_i & w_half[0]}}, w_half};
        misalign_o  = addr_off_i[1];
      end
      default: begin
        misalign_o  = |addr_off_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage                                              |
// | Description : DLX memory-access stage. Issues loads/stores over a    |
// |               req/ack data-memory port, stalls upstream while a      |
// |               transaction is outstanding, selects the integer        |
// |               writeback value and owns the MEM/WB register.          |
// | Ports       : EX/MEM inputs (nextPC, aluResult, memVal, controls,    |
// |               FP writeback bus); dmem_* request/ack port;            |
// |               stall_out to upstream; MEM/WB outputs (wbData,         |
// |               destReg, RegWrite, misalign, FP writeback).            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_stage
  import dlx_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] nextPC_in,
  input  logic [0:31] aluResult_in,
  input  logic [0:31] memVal_in,
  input  logic [0:4]  destReg_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemWrite_in,
  input  logic        loadSign_in,
  input  logic        PCtoReg_in,
  input  logic [1:0]  DSize_in,
  input  logic [0:63] fbusW_in,
  input  logic [0:4]  fDestReg_in,
  input  logic        FPRegWrite_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [0:31] dmem_addr_out,
  output logic [0:31] dmem_wdata_out,
  output logic [0:3]  dmem_be_out,
  input  logic        dmem_ack_in,
  input  logic [0:31] dmem_rdata_in,
  output logic        stall_out,
  output logic [0:31] wbData_out,
  output logic [0:4]  destReg_out,
  output logic        RegWrite_out,
  output logic        misalign_out,
  output logic [0:63] fbusW_out,
  output logic [0:4]  fDestReg_out,
  output logic        FPRegWrite_out
);

  mem_state_e  state_q, state_d;
  logic        w_mem_op, w_misalign, w_bad_op, w_issue, w_is_load, w_stall;
  logic [0:31] w_load_data, w_wb;
  logic [0:31] load_q;
  logic [0:31] wbData_q;
  logic [0:4]  destReg_q, fDestReg_q;
  logic        RegWrite_q, misalign_q, FPRegWrite_q;
  logic [0:63] fbusW_q;

  mem_align u_align (
    .addr_off_i  (aluResult_in[30:31]),
    .dsize_i     (DSize_in),
    .store_val_i (memVal_in),
    .load_sign_i (loadSign_in),
    .rdata_i     (dmem_rdata_in),
    .wdata_o     (dmem_wdata_out),
    .be_o        (dmem_be_out),
    .load_data_o (w_load_data),
    .misalign_o  (w_misalign)
  );

  // A store with MemToReg also set is treated as a plain store.
  assign w_mem_op  = MemWrite_in | MemToReg_in;
  assign w_bad_op  = w_mem_op & w_misalign;
  assign w_issue   = w_mem_op & ~w_misalign;
  assign w_is_load = MemToReg_in & ~MemWrite_in & ~w_misalign;

  assign dmem_addr_out = {aluResult_in[0:29], 2'b00};
  assign dmem_we_out   = dmem_req_out & MemWrite_in;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_issue)     state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ack_in) state_d = ST_DONE;
      ST_DONE:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Output logic; the request is a decode of the registered state.
  always_comb begin
    w_stall      = 1'b0;
    dmem_req_out = 1'b0;
    case (state_q)
      ST_IDLE:   w_stall = w_issue;
      ST_ACCESS: begin
        w_stall      = 1'b1;
        dmem_req_out = 1'b1;
      end
      default:   w_stall = 1'b0;
    endcase
    // Upstream is never held while the pipeline is being reset.
    stall_out = w_stall & ~reset;
  end

  // Load data is captured on ack and consumed in DONE.
  always_ff @(posedge clk) begin
    if (reset)                                    load_q <= '0;
    else if ((state_q == ST_ACCESS) && dmem_ack_in) load_q <= w_load_data;
  end

  assign w_wb = PCtoReg_in ? nextPC_in : (w_is_load ? load_q : aluResult_in);

  // MEM/WB register: loads the instruction when not stalled, else a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbData_q     <= '0;
      destReg_q    <= '0;
      RegWrite_q   <= 1'b0;
      misalign_q   <= 1'b0;
      fbusW_q      <= '0;
      fDestReg_q   <= '0;
      FPRegWrite_q <= 1'b0;
    end else if (!stall_out) begin
      wbData_q     <= w_wb;
      destReg_q    <= destReg_in;
      RegWrite_q   <= RegWrite_in & ~w_bad_op;
      misalign_q   <= w_bad_op;
      fbusW_q      <= fbusW_in;
      fDestReg_q   <= fDestReg_in;
      FPRegWrite_q <= FPRegWrite_in;
    end else begin
      RegWrite_q   <= 1'b0;
      misalign_q   <= 1'b0;
      FPRegWrite_q <= 1'b0;
    end
  end

  assign wbData_out     = wbData_q;
  assign destReg_out    = destReg_q;
  assign RegWrite_out   = RegWrite_q;
  assign misalign_out   = misalign_q;
  assign fbusW_out      = fbusW_q;
  assign fDestReg_out   = fDestReg_q;
  assign FPRegWrite_out = FPRegWrite_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_stage                                           |
// | Description : Scoreboard bench for mem_stage. Each instruction       |
// |               pushes its expected MEM/WB contents; a negedge monitor |
// |               pops and compares them when the stage retires it.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nextPC_in, aluResult_in, memVal_in;
  logic [4:0]  destReg_in;
  logic        RegWrite_in, MemToReg_in, MemWrite_in, loadSign_in, PCtoReg_in;
  logic [1:0]  DSize_in;
  logic [63:0] fbusW_in;
  logic [4:0]  fDestReg_in;
  logic        FPRegWrite_in;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;
  logic        stall_out;
  logic [31:0] wbData_out;
  logic [4:0]  destReg_out;
  logic        RegWrite_out, misalign_out;
  logic [63:0] fbusW_out;
  logic [4:0]  fDestReg_out;
  logic        FPRegWrite_out;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .nextPC_in(nextPC_in), .aluResult_in(aluResult_in), .memVal_in(memVal_in),
    .destReg_in(destReg_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemWrite_in(MemWrite_in), .loadSign_in(loadSign_in), .PCtoReg_in(PCtoReg_in),
    .DSize_in(DSize_in), .fbusW_in(fbusW_in), .fDestReg_in(fDestReg_in),
    .FPRegWrite_in(FPRegWrite_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_be_out(dmem_be_out), .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in),
    .stall_out(stall_out), .wbData_out(wbData_out), .destReg_out(destReg_out),
    .RegWrite_out(RegWrite_out), .misalign_out(misalign_out),
    .fbusW_out(fbusW_out), .fDestReg_out(fDestReg_out), .FPRegWrite_out(FPRegWrite_out)
  );

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  dest;
    logic        rw;
    logic        mis;
    logic [63:0] fbus;
    logic [4:0]  fdest;
    logic        fprw;
  } wb_t;

  wb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data-memory responder: acks after ack_delay extra request cycles.
  bit ack_auto  = 1'b1;
  bit ack_force = 1'b0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  always @(negedge clk) begin
    if (!ack_auto) begin
      dmem_ack_in = ack_force;
      wait_cnt    = 0;
    end else if (dmem_req_out) begin
      if (wait_cnt == ack_delay) begin
        dmem_ack_in = 1'b1;
        wait_cnt    = 0;
      end else begin
        dmem_ack_in = 1'b0;
        wait_cnt++;
      end
    end else begin
      dmem_ack_in = 1'b0;
      wait_cnt    = 0;
    end
  end

  // Retirement monitor.
  bit sb_en = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;

  always @(negedge clk) begin
    if (sb_en && prev_valid) begin
      if (!prev_stall) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          wb_t e;
          e = sb_q.pop_front();
          check_val("wbData",     wbData_out,     e.wb);
          check_val("destReg",    destReg_out,    e.dest);
          check_val("RegWrite",   RegWrite_out,   e.rw);
          check_val("misalign",   misalign_out,   e.mis);
          check_val("fbusW",      fbusW_out,      e.fbus);
          check_val("fDestReg",   fDestReg_out,   e.fdest);
          check_val("FPRegWrite", FPRegWrite_out, e.fprw);
        end
      end else begin
        check_val("bubble_rw",   RegWrite_out,   0);
        check_val("bubble_fprw", FPRegWrite_out, 0);
        check_val("bubble_mis",  misalign_out,   0);
      end
    end
    prev_stall = stall_out;
    prev_valid = sb_en && !reset;
  end

  // Drive one instruction, push its expected result, follow it to completion.
  task automatic issue(input logic [31:0] pc, alu, mval, input logic [4:0] dest,
                       input logic rw, m2r, mw, sgn, pc2r, input logic [1:0] ds,
                       input logic [63:0] fbus, input logic [4:0] fdest, input logic fprw,
                       input logic [31:0] rdata, input int delay);
    logic [1:0]  off;
    logic        memop, mis, iss, ld;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] lv, e_wdata;
    logic [3:0]  e_be;
    wb_t         e;
    int          stalls, reqs;
    bit          done;
    off   = alu[1:0];
    memop = mw | m2r;
    mis   = memop && ((ds == 2'b01 && off[0]) || (ds[1] && off != 2'b00));
    iss   = memop && !mis;
    ld    = m2r && !mw && !mis;
    b     = 8'(rdata >> (24 - 8 * int'(off)));
    h     = off[1] ? rdata[15:0] : rdata[31:16];
    if (ds == 2'b00) begin
      lv = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      e_be = 4'b1000 >> off;
      e_wdata = {4{mval[7:0]}};
    end else if (ds == 2'b01) begin
      lv = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      e_be = off[1] ? 4'b0011 : 4'b1100;
      e_wdata = {2{mval[15:0]}};
    end else begin
      lv = rdata;
      e_be = 4'b1111;
      e_wdata = mval;
    end
    e.wb    = pc2r ? pc : (ld ? lv : alu);
    e.dest  = dest;
    e.rw    = rw & ~mis;
    e.mis   = mis;
    e.fbus  = fbus;
    e.fdest = fdest;
    e.fprw  = fprw;

    nextPC_in = pc; aluResult_in = alu; memVal_in = mval; destReg_in = dest;
    RegWrite_in = rw; MemToReg_in = m2r; MemWrite_in = mw; loadSign_in = sgn;
    PCtoReg_in = pc2r; DSize_in = ds; fbusW_in = fbus; fDestReg_in = fdest;
    FPRegWrite_in = fprw; dmem_rdata_in = rdata; ack_delay = delay;
    sb_q.push_back(e);

    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (dmem_req_out) begin
        reqs++;
        check_val("dmem_addr",  dmem_addr_out, alu & 32'hFFFF_FFFC);
        check_val("dmem_be",    dmem_be_out,   e_be);
        check_val("dmem_we",    dmem_we_out,   mw);
        if (mw) check_val("dmem_wdata", dmem_wdata_out, e_wdata);
      end else begin
        check_val("we_idle", dmem_we_out, 0);
      end
      if (stall_out) stalls++;
      else           done = 1'b1;
    end
    if (!done) check_val("stall_timeout", 1, 0);
    check_val("stall_cycles", stalls, iss ? delay + 2 : 0);
    check_val("req_cycles",   reqs,   iss ? delay + 1 : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    nextPC_in = '0; aluResult_in = '0; memVal_in = '0; destReg_in = '0;
    RegWrite_in = 1'b0; MemToReg_in = 1'b0; MemWrite_in = 1'b0; loadSign_in = 1'b0;
    PCtoReg_in = 1'b0; DSize_in = 2'b10; fbusW_in = '0; fDestReg_in = '0;
    FPRegWrite_in = 1'b0; dmem_rdata_in = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_req",   dmem_req_out, 0);
    check_val("rst_stall", stall_out,    0);
    check_val("rst_wb",    wbData_out,   0);
    check_val("rst_rw",    RegWrite_out, 0);
    check_val("rst_mis",   misalign_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_en = 1'b1;

    //      pc          alu          mval         dst rw m2r mw sg p2r ds     fbus                    fd fp rdata        dly
    issue(32'h1000,    32'h0000_0007, 32'h0,       3, 1, 0, 0, 0, 0, 2'b10, 64'h0,                  0, 0, 32'h0,        0); // add
    issue(32'h1234,    32'h0000_0099, 32'h0,      31, 1, 0, 0, 0, 1, 2'b10, 64'h0,                  0, 0, 32'h0,        0); // link
    issue(32'h0,       32'h0000_0103, 32'h0,       4, 1, 1, 0, 1, 0, 2'b00, 64'h0,                  0, 0, 32'h11223380, 0); // lb
    issue(32'h0,       32'h0000_0103, 32'h0,       5, 1, 1, 0, 0, 0, 2'b00, 64'h0,                  0, 0, 32'h11223380, 0); // lbu
    issue(32'h0,       32'h0000_0202, 32'h0000ABCD,0, 0, 0, 1, 0, 0, 2'b01, 64'h0,                  0, 0, 32'h0,        0); // sh
    issue(32'h0,       32'h0000_0100, 32'h0,       6, 1, 1, 0, 0, 0, 2'b10, 64'h0,                  0, 0, 32'hDEADBEEF, 4); // lw slow
    issue(32'h0,       32'h0000_0102, 32'h0,       7, 1, 1, 0, 0, 0, 2'b10, 64'h0,                  0, 0, 32'h0,        0); // lw misaligned
    issue(32'h0,       32'h0000_0206, 32'h0,       8, 1, 1, 0, 1, 0, 2'b01, 64'h0,                  0, 0, 32'h1234F00D, 1); // lh
    issue(32'h0,       32'h0000_0101, 32'h1234565A,0, 0, 0, 1, 0, 0, 2'b00, 64'h0,                  0, 0, 32'h0,        0); // sb
    issue(32'h0,       32'h0000_0108, 32'hCAFEF00D,9, 1, 1, 1, 0, 0, 2'b11, 64'h0,                  0, 0, 32'h0,        0); // store wins
    issue(32'h0,       32'h0000_0055, 32'h0,       0, 0, 0, 0, 0, 0, 2'b10, 64'h0123456789ABCDEF,   9, 1, 32'h0,        0); // FP pass
    issue(32'h0,       32'h0000_0300, 32'h0,      10, 1, 1, 0, 0, 0, 2'b01, 64'h0,                  0, 0, 32'h80017777, 2); // lhu
    issue(32'h0,       32'h0000_0201, 32'h0000FFFF,0, 0, 0, 1, 0, 0, 2'b01, 64'h0,                  0, 0, 32'h0,        0); // sh misaligned
    issue(32'h0,       32'h0000_0077, 32'h0,      12, 1, 0, 0, 0, 0, 2'b10, 64'hFEED_0000_0000_BEEF,13, 1, 32'h0,        0); // add + FP
    @(negedge clk); #1;
    sb_en = 1'b0;
    check_val("sb_drain", sb_q.size(), 0);

    // Reset while a load is in ACCESS; a late ack must be ignored.
    @(posedge clk); #1;
    ack_auto = 1'b0; ack_force = 1'b0;
    aluResult_in = 32'h0000_0100; MemToReg_in = 1'b1; MemWrite_in = 1'b0;
    DSize_in = 2'b10; RegWrite_in = 1'b1; destReg_in = 5'd14; FPRegWrite_in = 1'b0;
    @(negedge clk);
    check_val("rs_idle_stall", stall_out, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rs_access_req", dmem_req_out, 1);
    @(posedge clk); #1;
    ack_force = 1'b1;
    @(negedge clk);
    check_val("rs_req",   dmem_req_out,   0);
    check_val("rs_we",    dmem_we_out,    0);
    check_val("rs_stall", stall_out,      0);
    check_val("rs_wb",    wbData_out,     0);
    check_val("rs_dest",  destReg_out,    0);
    check_val("rs_rw",    RegWrite_out,   0);
    check_val("rs_fbus",  fbusW_out,      0);
    check_val("rs_fprw",  FPRegWrite_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    MemToReg_in = 1'b0;
    @(negedge clk);
    check_val("rs_ack_ign_req",   dmem_req_out, 0);
    check_val("rs_ack_ign_stall", stall_out,    0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    check_val("rs_post_req", dmem_req_out, 0);
    @(posedge clk); #1;
    ack_auto = 1'b1;
    sb_en    = 1'b1;
    issue(32'h0, 32'h0000_0042, 32'h0, 2, 1, 0, 0, 0, 0, 2'b10, 64'h0, 0, 0, 32'h0, 0);
    issue(32'h0, 32'h0000_0400, 32'h0, 3, 1, 1, 0, 0, 0, 2'b10, 64'h0, 0, 0, 32'h0BADF00D, 0);
    @(negedge clk); #1;
    sb_en = 1'b0;
    check_val("sb_drain2", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
